// File: rtl/mul_share_arb_if.sv
// ---------------------------------------------------------------------------
// mul_share_arb_if
// Requester-side bundle of the shared-multiplier arbiter.
//   req_valid/req_ready : per-port request handshake (one-hot ready)
//   req_a/req_b         : per-port 32-bit operands, port i at [32i+31:32i]
//   resp_valid/resp_ready: per-port response handshake (one-hot valid)
//   resp_data           : 64-bit product shared by all ports
//   resp_err            : watchdog timeout flag, qualified by resp_valid
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mul_share_arb_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [NUM_REQ-1:0]    resp_ready;
   logic [63:0]           resp_data;
   logic                  resp_err;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/mul_share_arb.sv
// ---------------------------------------------------------------------------
// mul_share_arb
// Round-robin arbiter/sequencer sharing one 32x32 shift-add multiplier among
// NUM_REQ requesters. One operation is outstanding at a time:
// IDLE (grant) -> ISSUE (start pulse) -> WAIT (multiplier busy) -> RESP.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : requester interface (slave modport)
//   mul_start_o  : one-cycle start pulse to the multiplier
//   mul_a_o/_b_o : registered operands to the multiplier
//   mul_data_i   : multiplier product
//   mul_ready_i  : multiplier done level, only looked at in WAIT
// ---------------------------------------------------------------------------
module mul_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int WAIT_LIMIT = 40
) (
   input  logic           clk,
   input  logic           rst,
   mul_share_arb_if.slave bus,
   output logic           mul_start_o,
   output logic [31:0]    mul_a_o,
   output logic [31:0]    mul_b_o,
   input  logic [63:0]    mul_data_i,
   input  logic           mul_ready_i
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(WAIT_LIMIT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]    state_q,     state_d;
   logic [IW-1:0] last_gnt_q,  last_gnt_d;
   logic [IW-1:0] gnt_idx_q,   gnt_idx_d;
   logic [31:0]   mul_a_q,     mul_a_d;
   logic [31:0]   mul_b_q,     mul_b_d;
   logic [WW-1:0] wdog_q,      wdog_d;
   logic [63:0]   resp_data_q, resp_data_d;
   logic          resp_err_q,  resp_err_d;

   logic [31:0]   a_arr [NUM_REQ];
   logic [31:0]   b_arr [NUM_REQ];
   logic          win_found;
   logic [IW-1:0] win_idx;

   genvar g;
   for (g = 0; g < NUM_REQ; g++) begin : g_split
      assign a_arr[g] = bus.req_a[32*g +: 32];
      assign b_arr[g] = bus.req_b[32*g +: 32];
   end

   // Round-robin search starting one past the last winner. The sum is kept
   // one bit wider so the wrap can be done with a single subtraction.
   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, last_gnt_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
         end
         idx = sum[IW-1:0];
         if (!win_found && bus.req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      gnt_idx_d   = gnt_idx_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      wdog_d      = wdog_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               mul_a_d    = a_arr[win_idx];
               mul_b_d    = b_arr[win_idx];
               gnt_idx_d  = win_idx;
               last_gnt_d = win_idx;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_q + 1'b1;
            if (mul_ready_i) begin
               resp_data_d = mul_data_i;
               resp_err_d  = 1'b0;
               state_d     = S_RESP;
            end else if (wdog_q == WW'(WAIT_LIMIT - 1)) begin
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.resp_ready[gnt_idx_q]) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_gnt_q  <= IW'(NUM_REQ - 1);
         gnt_idx_q   <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         wdog_q      <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         wdog_q      <= wdog_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE && win_found) ?
                           (NUM_REQ'(1) << win_idx) : '0;
   assign bus.resp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;
   assign mul_start_o    = (state_q == S_ISSUE);
   assign mul_a_o        = mul_a_q;
   assign mul_b_o        = mul_b_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arb
// Bench for mul_share_arb with NUM_REQ=4, WAIT_LIMIT=40. Contains a simple
// shift-add multiplier timing model (ready 33 cycles after start, optional
// never-ready mode), a vector table of single transactions, hand-written
// corner sequences and a randomized phase checked against a
// transaction-timeline reference model.
// ---------------------------------------------------------------------------
module tb_mul_share_arb;
   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mul_start;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_data;
   logic        mul_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   mul_share_arb_if #(.NUM_REQ(NR)) bus ();

   mul_share_arb #(.NUM_REQ(NR), .WAIT_LIMIT(40)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mul_start_o (mul_start),
      .mul_a_o     (mul_a),
      .mul_b_o     (mul_b),
      .mul_data_i  (mul_data),
      .mul_ready_i (mul_ready)
   );

   always #5 clk = ~clk;

   // Multiplier model: ready drops on start, rises 33 edges later.
   // Starts with a stale high ready level.
   bit          never_ready = 1'b0;
   logic        mr_q   = 1'b1;
   int          mcnt   = 0;
   logic [63:0] mprod  = 64'hDEAD_BEEF_0BAD_F00D;
   always @(posedge clk) begin
      if (mul_start) begin
         mr_q  <= 1'b0;
         mprod <= 64'(mul_a) * 64'(mul_b);
         mcnt  <= never_ready ? 0 : 32;
      end else if (mcnt == 1) begin
         mr_q <= 1'b1;
         mcnt <= 0;
      end else if (mcnt > 1) begin
         mcnt <= mcnt - 1;
      end
   end
   assign mul_ready = mr_q;
   assign mul_data  = mprod;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [3:0] oh(input int p);
      logic [3:0] r;
      r = '0;
      r[p] = 1'b1;
      return r;
   endfunction

   // One complete transaction from a single requester.
   task automatic run_txn(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] exp_rdy, input logic [63:0] exp_p,
                          input bit exp_err);
      int lat;
      tick();
      bus.req_valid = oh(port);
      bus.req_a[32*port +: 32] = a;
      bus.req_b[32*port +: 32] = b;
      @(negedge clk);
      chk("txn_grant", 64'(bus.req_ready), 64'(exp_rdy));
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("txn_start", 64'(mul_start), 64'd1);
      chk("txn_mul_a", 64'(mul_a), 64'(a));
      chk("txn_mul_b", 64'(mul_b), 64'(b));
      lat = 1;
      do begin
         tick();
         @(negedge clk);
         lat++;
         if (lat == 2) chk("txn_start_one_cycle", 64'(mul_start), 64'd0);
      end while (bus.resp_valid == '0 && lat < 80);
      chk("txn_latency", 64'(lat), exp_err ? 64'd42 : 64'd35);
      chk("txn_resp_valid", 64'(bus.resp_valid), 64'(oh(port)));
      chk("txn_resp_data", bus.resp_data, exp_p);
      chk("txn_resp_err", 64'(bus.resp_err), 64'(exp_err));
      bus.resp_ready = oh(port);
      tick();
      bus.resp_ready = '0;
      @(negedge clk);
      chk("txn_resp_release", 64'(bus.resp_valid), 64'd0);
   endtask

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  exp_rdy;
      logic [63:0] exp_p;
   } vec_t;
   vec_t vecs[6];

   initial begin
      logic [31:0] pa[NR];
      logic [31:0] pb[NR];
      logic [3:0]  pv;
      int          m_last, m_port, m_cnt, winner, w, lat;
      bit          m_busy, ok;
      logic [63:0] m_prod, held;
      logic [3:0]  exp_rr, exp_rv;
      logic        exp_start;

      vecs[0] = '{0, 32'd3,          32'd5,          4'b0001, 64'd15};
      vecs[1] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b0010, 64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{2, 32'd0,          32'hDEAD_BEEF,  4'b0100, 64'd0};
      vecs[3] = '{3, 32'd1,          32'hFFFF_FFFF,  4'b1000, 64'h0000_0000_FFFF_FFFF};
      vecs[4] = '{0, 32'h8000_0000,  32'h8000_0000,  4'b0001, 64'h4000_0000_0000_0000};
      vecs[5] = '{2, 32'd10000,      32'd10000,      4'b0100, 64'd100000000};

      rst = 1'b1;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = '0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_mul_start", 64'(mul_start), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_resp_data", bus.resp_data, 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err), 64'd0);

      // Stale-high ready in IDLE must not produce anything.
      repeat (3) tick();
      @(negedge clk);
      chk("idle_stale_ready", 64'(bus.resp_valid), 64'd0);

      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp_rdy, vecs[i].exp_p, 1'b0);
      end

      // Round robin: all ports valid continuously.
      do_reset();
      for (int p = 0; p < NR; p++) begin
         pa[p] = 32'd100 + 32'(p);
         pb[p] = 32'd1000 + 32'(7 * p);
         bus.req_a[32*p +: 32] = pa[p];
         bus.req_b[32*p +: 32] = pb[p];
      end
      bus.req_valid  = 4'hF;
      bus.resp_ready = 4'hF;
      for (int gi = 0; gi < 5; gi++) begin
         @(negedge clk);
         w = 0;
         while (bus.req_ready == '0 && w < 60) begin
            tick();
            @(negedge clk);
            w++;
         end
         chk("rr_grant_order", 64'(bus.req_ready), 64'(oh(gi % NR)));
         w = 0;
         do begin
            tick();
            @(negedge clk);
            w++;
         end while (bus.resp_valid == '0 && w < 60);
         chk("rr_resp_port", 64'(bus.resp_valid), 64'(oh(gi % NR)));
         chk("rr_resp_data", bus.resp_data, 64'(pa[gi % NR]) * 64'(pb[gi % NR]));
         tick();
      end
      bus.req_valid  = '0;
      bus.resp_ready = '0;

      // Watchdog: multiplier never completes.
      never_ready = 1'b1;
      run_txn(3, 32'd12, 32'd13, 4'b1000, 64'd0, 1'b1);
      never_ready = 1'b0;

      // Response back-pressure with a competing requester.
      tick();
      bus.req_valid = 4'b0100;
      bus.req_a[64 +: 32] = 32'd7;
      bus.req_b[64 +: 32] = 32'd9;
      @(negedge clk);
      chk("bp_grant", 64'(bus.req_ready), 64'b0100);
      tick();
      bus.req_valid = 4'b0010;
      bus.req_a[32 +: 32] = 32'd21;
      bus.req_b[32 +: 32] = 32'd22;
      w = 0;
      do begin
         tick();
         @(negedge clk);
         w++;
      end while (bus.resp_valid == '0 && w < 60);
      bus.resp_ready = 4'b1011;
      for (int c = 0; c < 10; c++) begin
         chk("bp_resp_valid_held", 64'(bus.resp_valid), 64'b0100);
         chk("bp_resp_data_held", bus.resp_data, 64'd63);
         chk("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
         tick();
         @(negedge clk);
      end
      bus.resp_ready = 4'b0100;
      tick();
      bus.resp_ready = '0;
      @(negedge clk);
      chk("bp_release", 64'(bus.resp_valid), 64'd0);
      chk("bp_next_grant", 64'(bus.req_ready), 64'b0010);
      tick();
      bus.req_valid = '0;
      w = 0;
      do begin
         tick();
         @(negedge clk);
         w++;
      end while (bus.resp_valid == '0 && w < 60);
      chk("bp_second_data", bus.resp_data, 64'd462);
      bus.resp_ready = 4'b0010;
      tick();
      bus.resp_ready = '0;

      // Reset during WAIT.
      tick();
      bus.req_valid = 4'b0001;
      bus.req_a[0 +: 32] = 32'd1234;
      bus.req_b[0 +: 32] = 32'd5678;
      @(negedge clk);
      chk("rw_grant", 64'(bus.req_ready), 64'b0001);
      tick();
      bus.req_valid = '0;
      repeat (8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rw_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rw_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rw_mul_start", 64'(mul_start), 64'd0);
      chk("rw_mul_a", 64'(mul_a), 64'd0);
      chk("rw_mul_b", 64'(mul_b), 64'd0);
      chk("rw_resp_data", bus.resp_data, 64'd0);
      chk("rw_resp_err", 64'(bus.resp_err), 64'd0);
      ok = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         @(negedge clk);
         if (bus.resp_valid != '0 || mul_start) ok = 1'b0;
      end
      chk("rw_no_stale_resp", 64'(ok), 64'd1);
      run_txn(1, 32'd4000, 32'd3000, 4'b0010, 64'd12000000, 1'b0);

      // Randomized phase against a transaction-timeline reference.
      do_reset();
      m_last = NR - 1;
      m_busy = 1'b0;
      m_cnt  = 0;
      m_port = 0;
      m_prod = '0;
      pv     = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         for (int p = 0; p < NR; p++) begin
            if (!pv[p] && $urandom_range(0, 2) == 0) begin
               pv[p] = 1'b1;
               pa[p] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
               pb[p] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            bus.req_a[32*p +: 32] = pa[p];
            bus.req_b[32*p +: 32] = pb[p];
         end
         bus.req_valid  = pv;
         bus.resp_ready = 4'($urandom);
         @(negedge clk);
         exp_rr = '0;
         exp_rv = '0;
         exp_start = 1'b0;
         winner = -1;
         if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
               if (winner < 0 && pv[(m_last + k) % NR]) winner = (m_last + k) % NR;
            end
            if (winner >= 0) exp_rr = oh(winner);
         end else begin
            if (m_cnt == 1) exp_start = 1'b1;
            if (m_cnt >= 35) exp_rv = oh(m_port);
         end
         chk("rnd_req_ready", 64'(bus.req_ready), 64'(exp_rr));
         chk("rnd_resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
         chk("rnd_mul_start", 64'(mul_start), 64'(exp_start));
         if (exp_rv != '0) begin
            chk("rnd_resp_data", bus.resp_data, m_prod);
            chk("rnd_resp_err", 64'(bus.resp_err), 64'd0);
         end
         if (!m_busy) begin
            if (winner >= 0) begin
               m_busy = 1'b1;
               m_cnt  = 1;
               m_port = winner;
               m_last = winner;
               m_prod = 64'(pa[winner]) * 64'(pb[winner]);
               pv[winner] = 1'b0;
            end
         end else if (m_cnt >= 35 && bus.resp_ready[m_port]) begin
            m_busy = 1'b0;
         end else begin
            m_cnt++;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
